// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state encoding, lane width and log2 helper for dmem_bank
package dmem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int LANE_W = 8;

    // Ceiling log2, elaboration-time only; returns 0 for v <= 1.
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - one byte lane: 8-bit x DEPTH sync RAM with registered read (write-first when DMEM_BYPASS_EN)
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int AW    = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [LANE_W-1:0] wdata,
    input  logic              re,
    input  logic              rzero,
    input  logic [AW-1:0]     raddr,
    output logic [LANE_W-1:0] rdata
);

    logic [LANE_W-1:0] mem [DEPTH];
    logic [LANE_W-1:0] rd_byte;

`ifdef DMEM_BYPASS_EN
    assign rd_byte = (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
    assign rd_byte = mem[raddr];
`endif

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Out-of-range reads still load the register, but with zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rzero ? '0 : rd_byte;
        end
    end

endmodule

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-lane data memory with clear sweep, range check; DMEM_BYPASS_EN selects write-first
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DW             = 32,
    parameter int ADDR_BIT       = 32,
    parameter int DEPTH          = 4096,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DW/8-1:0]     mem_wen_i,
    input  logic [ADDR_BIT-1:0] mem_waddr_i,
    input  logic [DW-1:0]       mem_wdata_i,
    input  logic                mem_ren_i,
    input  logic [ADDR_BIT-1:0] mem_raddr_i,
    output logic [DW-1:0]       mem_rdata_o,
    output logic                mem_rvalid_o,
    output logic                mem_err_o,
    output logic                mem_busy_o
);

    localparam int NB  = DW / LANE_W;
    localparam int OFF = log2(NB);
    localparam int AW  = log2(DEPTH);
    localparam int HI  = AW + OFF;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q;
    logic          busy_q;
    logic          rvalid_q;
    logic          err_q;

    logic          clearing;
    logic          wr_req, rd_req;
    logic          wr_oor, rd_oor;
    logic [AW-1:0] wr_word, rd_word;

    assign clearing = (state_q == ST_CLEAR);

    // busy lags the state by one cycle, so accesses are gated on busy_q alone.
    assign wr_req  = (|mem_wen_i) && !busy_q;
    assign rd_req  = mem_ren_i && !busy_q;
    assign wr_oor  = |(mem_waddr_i >> HI);
    assign rd_oor  = |(mem_raddr_i >> HI);
    assign wr_word = AW'(mem_waddr_i >> OFF);
    assign rd_word = AW'(mem_raddr_i >> OFF);

    always_comb begin
        state_d = state_q;
        if (clearing && (clr_idx_q == AW'(DEPTH - 1))) begin
            state_d = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_idx_q <= '0;
            busy_q    <= (CLEAR_ON_RESET != 0);
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (clearing) clr_idx_q <= clr_idx_q + AW'(1);
            busy_q    <= clearing;
            rvalid_q  <= rd_req;
            err_q     <= (wr_req && wr_oor) || (rd_req && rd_oor);
        end
    end

    genvar k;
    generate
        for (k = 0; k < NB; k++) begin : g_lane
            logic              lane_we;
            logic [AW-1:0]     lane_waddr;
            logic [LANE_W-1:0] lane_wdata;

            assign lane_we    = clearing ? 1'b1 : (wr_req && !wr_oor && mem_wen_i[k]);
            assign lane_waddr = clearing ? clr_idx_q : wr_word;
            assign lane_wdata = clearing ? '0 : mem_wdata_i[LANE_W*k +: LANE_W];

            dmem_lane #(
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_lane (
                .clk   (clk),
                .rst   (rst),
                .we    (lane_we),
                .waddr (lane_waddr),
                .wdata (lane_wdata),
                .re    (rd_req),
                .rzero (rd_oor),
                .raddr (rd_word),
                .rdata (mem_rdata_o[LANE_W*k +: LANE_W])
            );
        end
    endgenerate

    assign mem_rvalid_o = rvalid_q;
    assign mem_err_o    = err_q;
    assign mem_busy_o   = busy_q;

endmodule

// File: tb/tb_dmem_bank.sv
// tb/tb_dmem_bank.sv - directed self-checking bench for dmem_bank (DEPTH = 16, clear on reset)
module tb_dmem_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  wen;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        busy;

    int checks;
    int fails;

    dmem_bank #(
        .DW             (32),
        .ADDR_BIT       (32),
        .DEPTH          (16),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_wen_i    (wen),
        .mem_waddr_i  (waddr),
        .mem_wdata_i  (wdata),
        .mem_ren_i    (ren),
        .mem_raddr_i  (raddr),
        .mem_rdata_o  (rdata),
        .mem_rvalid_o (rvalid),
        .mem_err_o    (err),
        .mem_busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wen   = 4'b0000;
        waddr = 32'h0;
        wdata = 32'h0;
        ren   = 1'b0;
        raddr = 32'h0;
    endtask

    // Counts cycles with busy high from the current cycle on; also counts rvalid pulses seen meanwhile.
    task automatic sweep_count(output int n, output int rv);
        n  = 0;
        rv = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            if (rvalid === 1'b1) rv++;
        end
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        wen = w; waddr = a; wdata = d;
        tick();
        idle();
    endtask

    task automatic read(input logic [31:0] a);
        ren = 1'b1; raddr = a;
        tick();
        idle();
    endtask

    int n, rv;

    initial begin
        checks = 0;
        fails  = 0;
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_rdata",  rdata, 32'h0);
        chk("reset_rvalid", {31'b0, rvalid}, 32'h0);
        chk("reset_err",    {31'b0, err}, 32'h0);
        chk("reset_busy",   {31'b0, busy}, 32'h1);

        // Sweep with requests hammering both ports; none may be accepted.
        rst = 1'b0;
        ren = 1'b1; raddr = 32'h0;
        wen = 4'b1111; waddr = 32'h24; wdata = 32'h5555_5555;
        sweep_count(n, rv);
        idle();
        chk("sweep_len",          n,  32'd17);
        chk("sweep_no_rvalid",    rv, 32'd0);
        chk("sweep_no_err",       {31'b0, err}, 32'h0);

        read(32'h3C);
        chk("clear_rd_3c_data",   rdata, 32'h0);
        chk("clear_rd_3c_valid",  {31'b0, rvalid}, 32'h1);
        chk("clear_rd_3c_err",    {31'b0, err}, 32'h0);
        tick();
        chk("rvalid_is_pulse",    {31'b0, rvalid}, 32'h0);

        read(32'h24);
        chk("busy_write_dropped", rdata, 32'h0);

        // Lane enables
        write(32'h10, 32'hDEAD_BEEF, 4'b1111);
        write(32'h10, 32'h0000_00AA, 4'b0001);
        read(32'h10);
        chk("lane_merge_data",    rdata, 32'hDEAD_BEAA);
        chk("lane_merge_valid",   {31'b0, rvalid}, 32'h1);
        tick();
        chk("hold_after_read",    rdata, 32'hDEAD_BEAA);
        chk("hold_rvalid_low",    {31'b0, rvalid}, 32'h0);

        // Same-cycle write and read of one word
        write(32'h20, 32'hAABB_CCDD, 4'b1111);
        wen = 4'b0011; waddr = 32'h20; wdata = 32'h1122_3344;
        ren = 1'b1;    raddr = 32'h20;
        tick();
        idle();
`ifdef DMEM_BYPASS_EN
        chk("same_cycle_rw",      rdata, 32'hAABB_3344);
`else
        chk("same_cycle_rw",      rdata, 32'hAABB_CCDD);
`endif
        read(32'h20);
        chk("after_partial_wr",   rdata, 32'hAABB_3344);

        // Out of range (DEPTH = 16: anything at or above 0x40)
        write(32'h0, 32'h1234_5678, 4'b1111);
        chk("inrange_wr_no_err",  {31'b0, err}, 32'h0);
        write(32'h0000_4000, 32'hFFFF_FFFF, 4'b1111);
        chk("oor_wr_err",         {31'b0, err}, 32'h1);
        chk("oor_wr_no_rvalid",   {31'b0, rvalid}, 32'h0);
        tick();
        chk("oor_err_pulse",      {31'b0, err}, 32'h0);
        read(32'h0000_4000);
        chk("oor_rd_data",        rdata, 32'h0);
        chk("oor_rd_valid",       {31'b0, rvalid}, 32'h1);
        chk("oor_rd_err",         {31'b0, err}, 32'h1);
        write(32'h0000_0040, 32'hFFFF_FFFF, 4'b1111);
        chk("oor_40_err",         {31'b0, err}, 32'h1);
        wen = 4'b1111; waddr = 32'h8000_0000; wdata = 32'hFFFF_FFFF;
        ren = 1'b1;    raddr = 32'h0000_0044;
        tick();
        idle();
        chk("oor_both_err",       {31'b0, err}, 32'h1);
        tick();
        chk("oor_both_one_pulse", {31'b0, err}, 32'h0);
        read(32'h0);
        chk("oor_word0_intact",   rdata, 32'h1234_5678);
        chk("oor_word0_no_err",   {31'b0, err}, 32'h0);

        // Back-to-back reads
        write(32'h4, 32'h0BAD_F00D, 4'b1111);
        write(32'h8, 32'hCAFE_0123, 4'b1111);
        ren = 1'b1; raddr = 32'h0;
        tick();
        chk("b2b_0_valid",        {31'b0, rvalid}, 32'h1);
        chk("b2b_0_data",         rdata, 32'h1234_5678);
        raddr = 32'h4;
        tick();
        chk("b2b_4_valid",        {31'b0, rvalid}, 32'h1);
        chk("b2b_4_data",         rdata, 32'h0BAD_F00D);
        raddr = 32'h8;
        tick();
        chk("b2b_8_valid",        {31'b0, rvalid}, 32'h1);
        chk("b2b_8_data",         rdata, 32'hCAFE_0123);
        idle();
        tick();
        chk("b2b_end_rvalid",     {31'b0, rvalid}, 32'h0);
        chk("b2b_hold_data",      rdata, 32'hCAFE_0123);

        // Reset pulsed mid-sweep at clr_idx = 7
        rst = 1'b1;
        tick();
        chk("rst_clears_rdata",   rdata, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("midsweep_busy",      {31'b0, busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ren = 1'b1; raddr = 32'h8;
        sweep_count(n, rv);
        idle();
        chk("resweep_len",        n,  32'd17);
        chk("resweep_no_rvalid",  rv, 32'd0);
        read(32'h10);
        chk("resweep_cleared_10", rdata, 32'h0);
        read(32'h3C);
        chk("resweep_cleared_3c", rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_bank.md
# dmem_bank

Parametrised byte-lane data memory for the RV32 core's load/store path, replacing the fixed 4-lane, 4096-word data RAM. It has one synchronous write port and one synchronous read port, and width, depth and lane count are generic. New behaviour over the previous generation:
- hardware zero-clear sweep after reset, with a busy indication;
- a registered read-valid strobe;
- out-of-range address detection;
- optional same-cycle write-to-read forwarding.

## Interface
- DW, 32: data width; must be a multiple of 8. NB = DW/8 byte lanes.
- ADDR_BIT, 32: address width (byte address).
- DEPTH, 4096: words per lane; must be a power of 2. AW = log2(DEPTH).
- CLEAR_ON_RESET, 1: 1 = zero-clear sweep after reset; 0 = memory contents undefined, block ready immediately.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-high.
- mem_wen_i  in  NB  per-lane write enables; bit k enables byte lane k.
- mem_waddr_i  in  ADDR_BIT  write byte address.
- mem_wdata_i  in  DW  write data; lane k = bits [8k+7:8k].
- mem_ren_i  in  1  read request.
- mem_raddr_i  in  ADDR_BIT  read byte address.
- mem_rdata_o  out  DW  registered read data.
- mem_rvalid_o  out  1  one-cycle pulse marking mem_rdata_o as new.
- mem_err_o  out  1  one-cycle pulse flagging an out-of-range access.
- mem_busy_o  out  1  high while the clear sweep runs; all accesses are ignored while high.

## Operation
- Address mapping:
  - OFF = log2(NB).
  - Word index = addr[AW+OFF-1:OFF].
  - Bits [OFF-1:0] are ignored; no misalignment handling.
  - Out of range = any of addr[ADDR_BIT-1:AW+OFF] nonzero.
- States:
  - CLEAR:
    - Counter clr_idx runs from 0 to DEPTH-1, writing 0 to all lanes at clr_idx, one word per cycle.
    - mem_busy_o = 1.
    - Port requests are dropped: no write, no rvalid, no err.
    - At clr_idx = DEPTH-1 the word is written and the state moves to READY.
  - READY: normal access; mem_busy_o = 0.
- Reset:
  - rst high forces state = CLEAR (CLEAR_ON_RESET = 1) or READY (CLEAR_ON_RESET = 0), and clr_idx = 0.
  - rst asserted mid-sweep restarts the sweep from index 0.
- Write: in READY, each lane k with mem_wen_i[k] = 1 and an in-range address stores its byte. Lanes with enable 0 are unchanged.
- Read:
  - In READY with mem_ren_i = 1 and an in-range address, the word is registered to mem_rdata_o and mem_rvalid_o pulses.
  - When no read occurs, mem_rdata_o holds its last value.
- Out of range:
  - The write is dropped.
  - The read loads mem_rdata_o = 0 and still pulses mem_rvalid_o.
  - mem_err_o pulses once per cycle, even if both ports are out of range.
- Same-word read and write in one cycle: see Configuration.

## Timing
- Reset values:
  - mem_rdata_o = 0, mem_rvalid_o = 0, mem_err_o = 0.
  - mem_busy_o = CLEAR_ON_RESET.
- Clear sweep: busy drops DEPTH+1 cycles after the first cycle with rst low. The first accepted request is in the cycle after busy falls.
- Read latency: 1 cycle. Request in cycle N gives data and rvalid in cycle N+1. Back-to-back reads are allowed every cycle.
- Write: takes effect at the edge ending cycle N and is visible to a read issued in cycle N+1.
- mem_err_o: asserted in cycle N+1 for an offending request in cycle N.

## Configuration
- DMEM_BYPASS_EN defined (write-first):
  - A same-cycle read of the word being written returns the new byte for lanes with mem_wen_i[k] = 1 and the stored byte for the other lanes.
- DMEM_BYPASS_EN undefined (read-first):
  - The read returns the old contents of all lanes.

## Structure
- Shared package dmem_pkg holds:
  - state encoding (CLEAR, READY);
  - lane width constant 8;
  - log2 helper function.
- Sub-module dmem_lane:
  - one 8-bit × DEPTH synchronous RAM plus its bypass mux;
  - instantiated NB times via generate.
- The top level holds the FSM, clr_idx counter, range check, rvalid/err registers and the clear-write mux.

## Test plan
- Reset, then sweep with DEPTH = 16:
  - busy stays high for 17 cycles after rst falls.
  - A read of address 0x3C right after busy falls returns 0x00000000.
- Write 0xDEADBEEF to 0x10 with wen = 4'b1111, then write 0x000000AA with wen = 4'b0001. A read of 0x10 returns 0xDEADBEAA with rvalid one cycle later.
- Same-cycle write of 0x11223344 to 0x20 (wen = 4'b0011, old content 0xAABBCCDD) and read of 0x20:
  - DMEM_BYPASS_EN defined: 0xAABB3344.
  - DMEM_BYPASS_EN undefined: 0xAABBCCDD.
- Out of range, DEPTH = 4096: write to 0x00004000.
  - err pulses one cycle later and the write is dropped.
  - A read of 0x00004000 returns 0 with rvalid = 1 and err = 1.
  - The memory at word 0 is unchanged.
- rst pulsed for 1 cycle mid-sweep at clr_idx = 7: the sweep restarts at 0; busy stays high for a full DEPTH+1 cycles after rst falls; no rvalid during busy.
- Back-to-back reads of 0x0, 0x4, 0x8 on consecutive cycles: rvalid is high for 3 consecutive cycles with the matching data. With ren low afterwards, rdata holds the 0x8 word.
